// File: rtl/estado_necesidad_pkg.sv
// Shared codes and default parameters for the need-tracking state machine.
// State codes double as display codes, so the two sets are kept identical.
package estado_necesidad_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_HAMBRE     = 3'd1;
  localparam logic [2:0] ST_DESNUTRIDO = 3'd2;
  localparam logic [2:0] ST_COMIENDO   = 3'd3;
  localparam logic [2:0] ST_ENFERMO    = 3'd4;

  localparam logic [2:0] VIS_IDLE       = ST_IDLE;
  localparam logic [2:0] VIS_HAMBRE     = ST_HAMBRE;
  localparam logic [2:0] VIS_DESNUTRIDO = ST_DESNUTRIDO;
  localparam logic [2:0] VIS_COMIENDO   = ST_COMIENDO;
  localparam logic [2:0] VIS_ENFERMO    = ST_ENFERMO;

  localparam int unsigned DEF_NIVEL_W        = 3;
  localparam int unsigned DEF_NIVEL_MAX      = 7;
  localparam int unsigned DEF_UMBRAL_HAMBRE  = 4;
  localparam int unsigned DEF_UMBRAL_CRITICO = 1;
  localparam int unsigned DEF_DIV_DECAE      = 50_000_000;
  localparam int unsigned DEF_DIV_COMIDA     = 12_500_000;
  localparam int unsigned DEF_T_ENFERMO      = 8;

endpackage

// File: rtl/estado_necesidad_divisor_tick.sv
// Prescaler: counts while en, pulses tick on the terminal count and wraps.
// clr has priority; holding en low freezes the count instead of clearing it.
module divisor_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= (cnt == TOP) ? '0 : cnt + CW'(1);
  end

  assign tick = en && !clr && (cnt == TOP);

endmodule

// File: rtl/estado_necesidad.sv
// Need-tracking FSM for one pet need: decaying level, feeding refill,
// sickness after prolonged malnutrition, registered display/enable outputs.
module estado_necesidad
  import estado_necesidad_pkg::*;
#(
  parameter int unsigned NIVEL_W        = DEF_NIVEL_W,
  parameter int unsigned NIVEL_MAX      = DEF_NIVEL_MAX,
  parameter int unsigned UMBRAL_HAMBRE  = DEF_UMBRAL_HAMBRE,
  parameter int unsigned UMBRAL_CRITICO = DEF_UMBRAL_CRITICO,
  parameter int unsigned DIV_DECAE      = DEF_DIV_DECAE,
  parameter int unsigned DIV_COMIDA     = DEF_DIV_COMIDA,
  parameter int unsigned T_ENFERMO      = DEF_T_ENFERMO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Boton_Comida,
  input  logic               Boton_Medicina,
  input  logic               Pausa,
  output logic [NIVEL_W-1:0] Nivel,
  output logic [2:0]         Estado,
  output logic [2:0]         Visualizacion,
  output logic               Activo_Comida,
  output logic               Activo_Medicina,
  output logic               Evento_Critico
);

  localparam logic [NIVEL_W-1:0] LV_MAX = NIVEL_W'(NIVEL_MAX);
  localparam logic [NIVEL_W-1:0] LV_HAM = NIVEL_W'(UMBRAL_HAMBRE);
  localparam logic [NIVEL_W-1:0] LV_CRI = NIVEL_W'(UMBRAL_CRITICO);
  localparam int unsigned        SW     = $clog2(T_ENFERMO + 1);
  localparam logic [SW-1:0]      S_LIM  = SW'(T_ENFERMO);

  logic [2:0]         estado_q, estado_d;
  logic [NIVEL_W-1:0] nivel_q;
  logic [SW-1:0]      sick_q;
  logic               med_q, med_edge;
  logic               comiendo, decae_en, decae_tick, comida_tick;
  logic               act_comida_d, act_med_d, evento_d;

  assign comiendo = (estado_q == ST_COMIENDO);
  assign decae_en = !Pausa && !comiendo;
  assign med_edge = Boton_Medicina && !med_q;

  divisor_tick #(.DIV(DIV_DECAE)) u_decae (
    .clk   (clk),
    .reset (reset),
    .en    (decae_en),
    .clr   (1'b0),
    .tick  (decae_tick)
  );

  divisor_tick #(.DIV(DIV_COMIDA)) u_comida (
    .clk   (clk),
    .reset (reset),
    .en    (comiendo),
    .clr   (!comiendo),
    .tick  (comida_tick)
  );

  // Level, sickness count and medicine edge register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nivel_q <= LV_MAX;
      sick_q  <= '0;
      med_q   <= 1'b0;
    end else begin
      med_q <= Boton_Medicina;
      if (decae_tick && nivel_q != '0)          nivel_q <= nivel_q - NIVEL_W'(1);
      else if (comida_tick && nivel_q < LV_MAX) nivel_q <= nivel_q + NIVEL_W'(1);
      if (estado_q == ST_DESNUTRIDO && estado_d == ST_DESNUTRIDO) begin
        if (decae_tick) sick_q <= sick_q + SW'(1);
      end else begin
        sick_q <= '0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q        <= ST_IDLE;
      Activo_Comida   <= 1'b1;
      Activo_Medicina <= 1'b1;
      Evento_Critico  <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      Activo_Comida   <= act_comida_d;
      Activo_Medicina <= act_med_d;
      Evento_Critico  <= evento_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE:
        if (nivel_q < LV_HAM) estado_d = ST_HAMBRE;
      ST_HAMBRE:
        if (nivel_q < LV_CRI)       estado_d = ST_DESNUTRIDO;
        else if (Boton_Comida)      estado_d = ST_COMIENDO;
        else if (nivel_q >= LV_HAM) estado_d = ST_IDLE;
      ST_DESNUTRIDO:
        if (Boton_Comida)           estado_d = ST_COMIENDO;
        else if (sick_q >= S_LIM)   estado_d = ST_ENFERMO;
      ST_COMIENDO:
        if (!(Boton_Comida && nivel_q < LV_MAX))
          estado_d = (nivel_q >= LV_HAM) ? ST_IDLE :
                     (nivel_q >= LV_CRI) ? ST_HAMBRE : ST_DESNUTRIDO;
      ST_ENFERMO:
        if (med_edge) estado_d = (nivel_q < LV_CRI) ? ST_DESNUTRIDO : ST_HAMBRE;
      default:
        estado_d = ST_IDLE;
    endcase
  end

  // Output values are derived from the next state so they flip with Estado
  always_comb begin
    act_comida_d = (estado_d != ST_ENFERMO);
    act_med_d    = (estado_d != ST_COMIENDO);
    evento_d     = (estado_d == ST_ENFERMO) && (estado_q != ST_ENFERMO);
  end

  assign Nivel         = nivel_q;
  assign Estado        = estado_q;
  assign Visualizacion = estado_q;

endmodule

// File: tb/tb_estado_necesidad.sv
// Bench for estado_necesidad: scenario tasks plus random traffic, all
// compared cycle by cycle against a rule-level reference model.
module tb_estado_necesidad;

  localparam int NW = 3, NMAX = 7, UH = 4, UC = 2, DD = 4, DC = 2, TE = 3;
  localparam int S_IDLE = 0, S_HAM = 1, S_DES = 2, S_COM = 3, S_ENF = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_c = 1'b0, btn_m = 1'b0, pausa = 1'b0;
  bit   ill = 1'b0;
  logic [NW-1:0] Nivel;
  logic [2:0] Estado, Visualizacion;
  logic Activo_Comida, Activo_Medicina, Evento_Critico;
  logic [11:0] dut_vec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  estado_necesidad #(
    .NIVEL_W(NW), .NIVEL_MAX(NMAX), .UMBRAL_HAMBRE(UH), .UMBRAL_CRITICO(UC),
    .DIV_DECAE(DD), .DIV_COMIDA(DC), .T_ENFERMO(TE)
  ) dut (
    .clk(clk), .reset(reset), .Boton_Comida(btn_c), .Boton_Medicina(btn_m),
    .Pausa(pausa), .Nivel(Nivel), .Estado(Estado), .Visualizacion(Visualizacion),
    .Activo_Comida(Activo_Comida), .Activo_Medicina(Activo_Medicina),
    .Evento_Critico(Evento_Critico)
  );

  assign dut_vec = {Nivel, Estado, Visualizacion, Activo_Comida, Activo_Medicina, Evento_Critico};

  typedef struct {
    int nivel, st, dcnt, fcnt, sick;
    bit medp, ac, am, ev;
  } model_t;

  model_t m;

  function automatic model_t m_rst();
    model_t r;
    r.nivel = NMAX; r.st = S_IDLE; r.dcnt = 0; r.fcnt = 0; r.sick = 0;
    r.medp = 0; r.ac = 1; r.am = 1; r.ev = 0;
    return r;
  endfunction

  function automatic int classify(int lv);
    if (lv >= UH) return S_IDLE;
    if (lv >= UC) return S_HAM;
    return S_DES;
  endfunction

  // One clock of the pet's rules, all decisions taken on pre-edge values
  function automatic model_t step(model_t c, bit bc, bit bm, bit pa, bit il);
    model_t n;
    int st, nx;
    bit dec_on, dt, ft, medge;
    n = c;
    st = il ? 6 : c.st;
    dec_on = !pa && st != S_COM;
    dt = dec_on && c.dcnt == DD - 1;
    ft = st == S_COM && c.fcnt == DC - 1;
    medge = bm && !c.medp;
    n.dcnt = dec_on ? (c.dcnt + 1) % DD : c.dcnt;
    n.fcnt = (st == S_COM) ? (c.fcnt + 1) % DC : 0;
    n.medp = bm;
    case (st)
      S_IDLE: nx = (c.nivel < UH) ? S_HAM : S_IDLE;
      S_HAM:  nx = (c.nivel < UC) ? S_DES : bc ? S_COM : (c.nivel >= UH) ? S_IDLE : S_HAM;
      S_DES:  nx = bc ? S_COM : (c.sick >= TE) ? S_ENF : S_DES;
      S_COM:  nx = (bc && c.nivel < NMAX) ? S_COM : classify(c.nivel);
      S_ENF:  nx = medge ? ((c.nivel < UC) ? S_DES : S_HAM) : S_ENF;
      default: nx = S_IDLE;
    endcase
    n.sick = (st == S_DES && nx == S_DES) ? c.sick + int'(dt) : 0;
    if (dt)      n.nivel = (c.nivel > 0) ? c.nivel - 1 : 0;
    else if (ft) n.nivel = (c.nivel < NMAX) ? c.nivel + 1 : NMAX;
    n.ev = (nx == S_ENF) && (st != S_ENF);
    n.ac = (nx != S_ENF);
    n.am = (nx != S_COM);
    n.st = nx;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= m_rst();
    else        m <= step(m, btn_c, btn_m, pausa, ill);
  end

  function automatic logic [11:0] exp_vec();
    return {NW'(m.nivel), 3'(m.st), 3'(m.st), m.ac, m.am, m.ev};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; btn_c = 0; btn_m = 0; pausa = 0; ill = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec !== {3'd7, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec, {3'd7, 3'd0, 3'd0, 3'b110});
    end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL free_run e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (e == 16) begin
        checks++;
        if (Nivel !== 3'd3 || Estado !== 3'd0) begin
          failures++; $display("FAIL free_run_lvl3 nivel=%0d estado=%0d exp 3/0", Nivel, Estado);
        end
      end
      if (e == 17) begin
        checks++;
        if (Estado !== 3'd1) begin failures++; $display("FAIL free_run_hambre got=%0d exp=1", Estado); end
      end
      if (e == 25) begin
        checks++;
        if (Estado !== 3'd2 || Nivel !== 3'd1) begin
          failures++; $display("FAIL free_run_desnutrido estado=%0d nivel=%0d exp 2/1", Estado, Nivel);
        end
      end
    end
  endtask

  task automatic test_feed();
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL feed e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (e == 18) begin
        checks++;
        if (Estado !== 3'd3 || Activo_Medicina !== 1'b0 || Nivel !== 3'd3) begin
          failures++; $display("FAIL feed_enter estado=%0d am=%0b nivel=%0d exp 3/0/3", Estado, Activo_Medicina, Nivel);
        end
      end
      if (e == 26) begin
        checks++;
        if (Nivel !== 3'd7 || Estado !== 3'd3) begin
          failures++; $display("FAIL feed_full nivel=%0d estado=%0d exp 7/3", Nivel, Estado);
        end
      end
      if (e == 27) begin
        checks++;
        if (Estado !== 3'd0 || Activo_Medicina !== 1'b1) begin
          failures++; $display("FAIL feed_exit_held estado=%0d am=%0b exp 0/1", Estado, Activo_Medicina);
        end
      end
      if (e == 17) btn_c = 1'b1;
      if (e == 30) btn_c = 1'b0;
    end
  endtask

  task automatic test_release();
    // release at level 5
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL release5 e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (e == 23) begin
        checks++;
        if (Estado !== 3'd0 || Nivel !== 3'd5) begin
          failures++; $display("FAIL release5_idle estado=%0d nivel=%0d exp 0/5", Estado, Nivel);
        end
      end
      if (e == 17) btn_c = 1'b1;
      if (e == 22) btn_c = 1'b0;
    end
    // release at level 1
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL release1 e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (e == 27) begin
        checks++;
        if (Estado !== 3'd2 || Nivel !== 3'd1) begin
          failures++; $display("FAIL release1_desn estado=%0d nivel=%0d exp 2/1", Estado, Nivel);
        end
      end
      if (e == 25) btn_c = 1'b1;
      if (e == 26) btn_c = 1'b0;
    end
    // press coinciding with a decay tick in HAMBRE
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL press_tick e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (e == 20) begin
        checks++;
        if (Estado !== 3'd3 || Nivel !== 3'd2) begin
          failures++; $display("FAIL press_tick_dec estado=%0d nivel=%0d exp 3/2", Estado, Nivel);
        end
      end
      if (e == 19) btn_c = 1'b1;
      if (e == 20) btn_c = 1'b0;
    end
  endtask

  task automatic test_sick();
    do_reset();
    for (int e = 1; e <= 62; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL sick e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (e == 36) begin
        checks++;
        if (Estado !== 3'd2) begin failures++; $display("FAIL sick_pre got=%0d exp=2", Estado); end
      end
      if (e == 37) begin
        checks++;
        if (Estado !== 3'd4 || Evento_Critico !== 1'b1 || Activo_Comida !== 1'b0) begin
          failures++; $display("FAIL sick_enter estado=%0d ev=%0b ac=%0b exp 4/1/0", Estado, Evento_Critico, Activo_Comida);
        end
      end
      if (e == 38) begin
        checks++;
        if (Evento_Critico !== 1'b0) begin failures++; $display("FAIL sick_pulse_width ev=%0b exp=0", Evento_Critico); end
      end
      if (e == 44) begin
        checks++;
        if (Estado !== 3'd4) begin failures++; $display("FAIL sick_food_ignored got=%0d exp=4", Estado); end
      end
      if (e == 45) begin
        checks++;
        if (Estado !== 3'd2 || Nivel !== 3'd0) begin
          failures++; $display("FAIL sick_medicine estado=%0d nivel=%0d exp 2/0", Estado, Nivel);
        end
      end
      if (e == 56 || e == 57 || e == 60) begin
        checks++;
        if (Estado !== ((e == 56) ? 3'd2 : 3'd4)) begin
          failures++; $display("FAIL sick_recount e=%0d got=%0d exp=%0d", e, Estado, (e == 56) ? 2 : 4);
        end
      end
      if (e == 38) btn_c = 1'b1;
      if (e == 44) begin btn_c = 1'b0; btn_m = 1'b1; end
      if (e == 45) btn_m = 1'b0;
      if (e == 49) btn_m = 1'b1;
      if (e == 60) btn_m = 1'b0;
    end
  endtask

  task automatic test_pause();
    do_reset();
    for (int e = 1; e <= 42; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL pause e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (e == 38 || e == 39) begin
        checks++;
        if (Nivel !== 3'd3 || Estado !== 3'd1) begin
          failures++; $display("FAIL pause_frozen e=%0d nivel=%0d estado=%0d exp 3/1", e, Nivel, Estado);
        end
      end
      if (e == 40) begin
        checks++;
        if (Nivel !== 3'd2) begin failures++; $display("FAIL pause_resume nivel=%0d exp=2", Nivel); end
      end
      if (e == 18) pausa = 1'b1;
      if (e == 38) pausa = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_c = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      @(negedge clk);
      if (e == 17) btn_c = 1'b1;
    end
    checks++;
    if (Estado !== 3'd3) begin failures++; $display("FAIL reset_mid_pre got=%0d exp=3", Estado); end
    #2 reset = 1'b0;
    btn_c = 1'b0;
    #1;
    checks++;
    if (Nivel !== 3'd7 || Estado !== 3'd0 || Activo_Comida !== 1'b1 || Activo_Medicina !== 1'b1) begin
      failures++; $display("FAIL reset_async nivel=%0d estado=%0d ac=%0b am=%0b exp 7/0/1/1",
                           Nivel, Estado, Activo_Comida, Activo_Medicina);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL reset_mid e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if (e == 3 || e == 4) begin
        checks++;
        if (Nivel !== ((e == 3) ? 3'd7 : 3'd6)) begin
          failures++; $display("FAIL reset_mid_counts e=%0d nivel=%0d exp=%0d", e, Nivel, (e == 3) ? 7 : 6);
        end
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    repeat (5) @(negedge clk);
    force dut.estado_q = 3'd6;
    ill = 1'b1;
    #1 release dut.estado_q;
    checks++;
    if (Estado !== 3'd6 || Visualizacion !== 3'd6) begin
      failures++; $display("FAIL illegal_inject estado=%0d vis=%0d exp 6/6", Estado, Visualizacion);
    end
    @(negedge clk);
    ill = 1'b0;
    checks++;
    if (Estado !== 3'd0 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL illegal_recover got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int e = 1; e <= 800; e++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL random e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
      end
      if ($urandom_range(0, 11) == 0) btn_c = ~btn_c;
      if ($urandom_range(0, 14) == 0) pausa = ~pausa;
      btn_m = ($urandom_range(0, 5) == 0);
    end
    btn_c = 0; btn_m = 0; pausa = 0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_feed();
    test_release();
    test_sick();
    test_pause();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
